// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core's memory port arbiter.
package cpu_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    // Identity of the requester that owns (or last owned) the memory port.
    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    // Cycles from address valid to read data valid at the memory port.
    localparam int DEFAULT_MEM_LATENCY = 2;

endpackage : cpu_pkg

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store.
// One transaction at a time: IDLE (arbitrate) -> ACCESS (wait latency) -> ACK.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  resetIn,

    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic                  fetchAcknowledge,
    output logic [DATA_WIDTH-1:0] fetchData,

    input  logic                  dataRequest,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    output logic                  dataAcknowledge,
    output logic [DATA_WIDTH-1:0] dataReadData,

    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWriteEnable,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    // Latency counter only ever counts 0 .. MEM_LATENCY-1, so it never wraps.
    localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    arb_state_e            state_q, state_d;
    grant_e                grant_q, grant_d;
    grant_e                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

    // Fetch wins when it is alone, or on a tie when data owned the last grant.
    logic pick_fetch;
    assign pick_fetch = fetchRequest && (!dataRequest || (last_grant_q == GRANT_DATA));

    // Next-state and datapath update for arbitration, latency wait and acknowledge.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (fetchRequest || dataRequest) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    if (pick_fetch) begin
                        grant_d    = GRANT_FETCH;
                        mem_addr_d = fetchAddress;
                        write_d    = 1'b0;
                    end else begin
                        grant_d     = GRANT_DATA;
                        mem_addr_d  = dataAddress;
                        mem_wdata_d = dataWriteData;
                        write_d     = dataWrite;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    if (grant_q == GRANT_FETCH) begin
                        fetch_data_d = memReadData;
                    end else if (!write_q) begin
                        // Stores leave the last loaded word untouched.
                        data_rdata_d = memReadData;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; a reset mid-transaction simply abandons it.
    always_ff @(posedge CLOCK_50) begin
        if (resetIn) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_FETCH;
            last_grant_q <= GRANT_DATA;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Outputs are registers or decodes of registered state only.
    assign memAddress       = mem_addr_q;
    assign memWriteData     = mem_wdata_q;
    assign memWriteEnable   = (state_q == ACCESS) && write_q && (cnt_q == '0);
    assign fetchAcknowledge = (state_q == ACK) && (grant_q == GRANT_FETCH);
    assign dataAcknowledge  = (state_q == ACK) && (grant_q == GRANT_DATA);
    assign fetchData        = fetch_data_q;
    assign dataReadData     = data_rdata_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int LAT = 2;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        f_req, f_ack, d_req, d_wr, d_ack, m_we;
    logic [31:0] f_addr, f_data, d_addr, d_wd, d_rd, m_addr, m_wd, m_rd;

    logic        f_req4, f_ack4, d_req4, d_wr4, d_ack4, m_we4;
    logic [31:0] f_addr4, f_data4, d_addr4, d_wd4, d_rd4, m_addr4, m_wd4, m_rd4;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLOCK_50(clk), .resetIn(rst),
        .fetchRequest(f_req), .fetchAddress(f_addr), .fetchAcknowledge(f_ack), .fetchData(f_data),
        .dataRequest(d_req), .dataWrite(d_wr), .dataAddress(d_addr), .dataWriteData(d_wd),
        .dataAcknowledge(d_ack), .dataReadData(d_rd),
        .memAddress(m_addr), .memWriteData(m_wd), .memWriteEnable(m_we), .memReadData(m_rd)
    );

    mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut4 (
        .CLOCK_50(clk), .resetIn(rst),
        .fetchRequest(f_req4), .fetchAddress(f_addr4), .fetchAcknowledge(f_ack4), .fetchData(f_data4),
        .dataRequest(d_req4), .dataWrite(d_wr4), .dataAddress(d_addr4), .dataWriteData(d_wd4),
        .dataAcknowledge(d_ack4), .dataReadData(d_rd4),
        .memAddress(m_addr4), .memWriteData(m_wd4), .memWriteEnable(m_we4), .memReadData(m_rd4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Environment memory (what the DUT really talks to) and the model's own view.
    logic [31:0] env_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    logic        mem_force;
    logic [31:0] force_word;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        if ($isunknown(a)) return 32'h0;
        if (env_mem.exists(a)) return env_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; memory behaves as a synchronous RAM (one-cycle read register).
    task automatic step();
        logic [31:0] a, wd;
        logic        we;
        a  = m_addr;
        wd = m_wd;
        we = m_we;
        @(posedge clk);
        #1;
        cyc++;
        if (we === 1'b1) env_mem[a] = wd;
        m_rd = mem_force ? force_word : env_read(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        freq, dreq, dwr;
        logic [31:0] faddr, daddr, dwd, rword;
        logic        exp_fack, exp_dack, exp_we;
        logic [31:0] exp_addr, exp_wd, exp_fdata, exp_ddata;
    } vec_t;

    vec_t vecs [7];

    // Random-phase model state.
    int          free_at, ack_at, grant_c;
    grant_e      who, last;
    logic        cur_we, f_pend, d_pend, f_rel, d_rel;
    logic [31:0] e_addr, e_wd, e_fdata, e_ddata, e_word;

    initial begin
        rst = 1'b1;
        f_req = 0; f_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wd = 0; m_rd = 0;
        f_req4 = 0; f_addr4 = 0; d_req4 = 0; d_wr4 = 0; d_addr4 = 0; d_wd4 = 0; m_rd4 = 0;
        mem_force = 1'b0;
        force_word = 0;

        //            freq dreq dwr faddr         daddr         dwd           rword         fack dack we  addr          wd            fdata         ddata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h8C08_0004,
                    1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h8C08_0004, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h1001_0008, 32'hDEAD_BEEF, 32'h1234_5678,
                    1'b0, 1'b1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h8C08_0004, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h1001_0010, 32'hAAAA_0000, 32'hCAFE_F00D,
                    1'b0, 1'b1, 1'b0, 32'h1001_0010, 32'hAAAA_0000, 32'h8C08_0004, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0040_0004, 32'h1001_0014, 32'h55AA_55AA, 32'h1111_2222,
                    1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'hAAAA_0000, 32'h1111_2222, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0040_0008, 32'h1001_0020, 32'h0BAD_F00D, 32'h3333_4444,
                    1'b0, 1'b1, 1'b0, 32'h1001_0020, 32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0040_000C, 32'h1001_0024, 32'h7777_8888, 32'h9999_AAAA,
                    1'b1, 1'b0, 1'b0, 32'h0040_000C, 32'h0BAD_F00D, 32'h9999_AAAA, 32'h3333_4444};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h1001_0028, 32'h1357_2468, 32'hFFFF_0000,
                    1'b0, 1'b1, 1'b1, 32'h1001_0028, 32'h1357_2468, 32'h9999_AAAA, 32'h3333_4444};

        // Reset state.
        step();
        step();
        check("reset fetchAck", f_ack, 0);
        check("reset dataAck", d_ack, 0);
        check("reset memWE", m_we, 0);
        check("reset memAddress", m_addr, 0);
        check("reset memWriteData", m_wd, 0);
        check("reset fetchData", f_data, 0);
        check("reset dataReadData", d_rd, 0);
        check("reset dut4 dataAck", d_ack4, 0);
        rst = 1'b0;

        // Directed vector table, back to back with one IDLE cycle between transactions.
        mem_force = 1'b1;
        for (int i = 0; i < 7; i++) begin
            int fa, da, wec;
            fa = 0; da = 0; wec = 0;
            f_req = vecs[i].freq; d_req = vecs[i].dreq; d_wr = vecs[i].dwr;
            f_addr = vecs[i].faddr; d_addr = vecs[i].daddr; d_wd = vecs[i].dwd;
            force_word = vecs[i].rword;
            for (int k = 1; k <= 3; k++) begin
                step();
                fa += int'(f_ack);
                da += int'(d_ack);
                wec += int'(m_we);
                if (k == 1) begin
                    check($sformatf("vec%0d memAddress", i), m_addr, vecs[i].exp_addr);
                    check($sformatf("vec%0d memWriteData", i), m_wd, vecs[i].exp_wd);
                    check($sformatf("vec%0d memWE at T+1", i), m_we, vecs[i].exp_we);
                end
                if (k == 3) begin
                    check($sformatf("vec%0d fetchAck at T+3", i), f_ack, vecs[i].exp_fack);
                    check($sformatf("vec%0d dataAck at T+3", i), d_ack, vecs[i].exp_dack);
                    check($sformatf("vec%0d fetchData", i), f_data, vecs[i].exp_fdata);
                    check($sformatf("vec%0d dataReadData", i), d_rd, vecs[i].exp_ddata);
                    check($sformatf("vec%0d memAddress held", i), m_addr, vecs[i].exp_addr);
                    f_req = 1'b0;
                    d_req = 1'b0;
                end
            end
            check($sformatf("vec%0d fetchAck count", i), fa, 32'(vecs[i].exp_fack));
            check($sformatf("vec%0d dataAck count", i), da, 32'(vecs[i].exp_dack));
            check($sformatf("vec%0d memWE count", i), wec, 32'(vecs[i].exp_we));
            step();
        end
        mem_force = 1'b0;

        // Tie after reset: grants alternate fetch, data, ... every 4 cycles.
        do_reset();
        f_req = 1'b1; f_addr = 32'h0040_0020;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h1001_0004;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("tie fetchAck k=%0d", k), f_ack, (k == 3 || k == 11) ? 1 : 0);
            check($sformatf("tie dataAck k=%0d", k), d_ack, (k == 7 || k == 15) ? 1 : 0);
            if (k == 15) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end

        // Request held for a single IDLE cycle still completes.
        f_req = 1'b1; f_addr = 32'h0040_0040;
        step();
        f_req = 1'b0;
        check("drop fetchAck T+1", f_ack, 0);
        step();
        check("drop fetchAck T+2", f_ack, 0);
        step();
        check("drop fetchAck T+3", f_ack, 1);
        check("drop fetchData", f_data, dflt(32'h0040_0040));
        step();

        // Reset during ACCESS of a store: no ack, outputs cleared, strobe not undone.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h1001_0030; d_wd = 32'h2468_2468;
        step();
        check("abort store strobe", m_we, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort dataAck", d_ack, 0);
        check("abort fetchAck", f_ack, 0);
        check("abort memAddress", m_addr, 0);
        check("abort memWriteData", m_wd, 0);
        check("abort fetchData", f_data, 0);
        check("abort dataReadData", d_rd, 0);
        check("abort memWE", m_we, 0);
        check("abort write kept", env_read(32'h1001_0030), 32'h2468_2468);
        f_req = 1'b1; f_addr = 32'h0040_0044;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h1001_0034;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("post-reset tie fetchAck k=%0d", k), f_ack, (k == 3) ? 1 : 0);
            check($sformatf("post-reset tie dataAck k=%0d", k), d_ack, 0);
        end
        f_req = 1'b0;
        d_req = 1'b0;
        step();

        // Latency-4 build: word only valid on memReadData in cycle T+4.
        d_req4 = 1'b1; d_wr4 = 1'b0; d_addr4 = 32'h1001_0040; m_rd4 = 32'hBAD0_BAD0;
        for (int k = 1; k <= 5; k++) begin
            step();
            m_rd4 = (k == 4) ? 32'h600D_F00D : 32'hBAD0_BAD0;
            if (k == 1) check("lat4 memAddress", m_addr4, 32'h1001_0040);
            check($sformatf("lat4 dataAck k=%0d", k), d_ack4, (k == 5) ? 1 : 0);
            if (k == 5) begin
                check("lat4 dataReadData", d_rd4, 32'h600D_F00D);
                d_req4 = 1'b0;
            end
        end
        step();

        // Randomized traffic against a transaction-level model.
        do_reset();
        env_mem.delete();
        model_mem.delete();
        free_at = cyc; ack_at = -1; grant_c = -10;
        who = GRANT_FETCH; last = GRANT_DATA; cur_we = 1'b0;
        f_pend = 0; d_pend = 0; f_rel = 0; d_rel = 0;
        e_addr = 0; e_wd = 0; e_fdata = 0; e_ddata = 0; e_word = 0;
        for (int n = 0; n < 2000; n++) begin
            if (cyc == ack_at) begin
                if (who == GRANT_FETCH) e_fdata = e_word;
                else if (!cur_we) e_ddata = e_word;
            end
            check("rnd fetchAck", f_ack, (cyc == ack_at && who == GRANT_FETCH) ? 1 : 0);
            check("rnd dataAck", d_ack, (cyc == ack_at && who == GRANT_DATA) ? 1 : 0);
            check("rnd fetchData", f_data, e_fdata);
            check("rnd dataReadData", d_rd, e_ddata);
            check("rnd memAddress", m_addr, e_addr);
            check("rnd memWriteData", m_wd, e_wd);
            check("rnd memWE", m_we, (cyc == grant_c + 1 && cur_we) ? 1 : 0);

            if (f_rel) begin f_pend = 1'b0; f_rel = 1'b0; end
            if (d_rel) begin d_pend = 1'b0; d_rel = 1'b0; end
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1'b1;
                f_addr = 32'h0040_0000 + 32'($urandom_range(0, 15) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_wr   = 1'($urandom_range(0, 1));
                d_addr = 32'h1001_0000 + 32'($urandom_range(0, 7) << 2);
                d_wd   = $urandom();
            end
            f_req = f_pend;
            d_req = d_pend;
            if (cyc == ack_at) begin
                if (who == GRANT_FETCH) f_rel = 1'b1;
                else d_rel = 1'b1;
            end

            if (cyc >= free_at && (f_req || d_req)) begin
                if (f_req && d_req) who = (last == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
                else who = f_req ? GRANT_FETCH : GRANT_DATA;
                last    = who;
                grant_c = cyc;
                ack_at  = cyc + LAT + 1;
                free_at = cyc + LAT + 2;
                if (who == GRANT_FETCH) begin
                    e_addr = f_addr;
                    cur_we = 1'b0;
                    e_word = model_read(f_addr);
                end else begin
                    e_addr = d_addr;
                    e_wd   = d_wd;
                    cur_we = d_wr;
                    if (d_wr) model_mem[d_addr] = d_wd;
                    e_word = model_read(d_addr);
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single synchronous memory port between the instruction-fetch requester and the load/store (data) requester of the multi-cycle MIPS core. Each requester uses a level request / one-cycle acknowledge handshake. The arbiter grants one requester at a time, with round-robin on ties. It drives the memory address, write data and write enable, waits a fixed memory latency, captures read data and returns it with the acknowledge.

## Interface
- MEM_LATENCY, 2, cycles from address valid to read data valid at the port (legal range ≥1).
- ADDR_WIDTH, 32, address width of requesters and memory port.
- DATA_WIDTH, 32, data width.

Ports:
- CLOCK_50  in  1  single clock; all state updates on rising edge.
- resetIn  in  1  synchronous, active-high reset.
- fetchRequest  in  1  fetch wants a read; level, held until fetchAcknowledge.
- fetchAddress  in  ADDR_WIDTH  fetch read address (PC).
- fetchAcknowledge  out  1  one-cycle pulse; fetchData valid this cycle.
- fetchData  out  DATA_WIDTH  captured instruction word.
- dataRequest  in  1  load/store wants access; level, held until dataAcknowledge.
- dataWrite  in  1  1 = store, 0 = load; sampled at grant.
- dataAddress  in  ADDR_WIDTH  load/store address.
- dataWriteData  in  DATA_WIDTH  store data.
- dataAcknowledge  out  1  one-cycle pulse; dataReadData valid this cycle (loads).
- dataReadData  out  DATA_WIDTH  captured load word.
- memAddress  out  ADDR_WIDTH  memory port address (registered).
- memWriteData  out  DATA_WIDTH  memory port write data (registered).
- memWriteEnable  out  1  memory write strobe.
- memReadData  in  DATA_WIDTH  memory port read data.

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not in lastGrant.
  - On grant: register the granted address into memAddress. For a data grant, also register dataWriteData into memWriteData and dataWrite into a write flag. Load the latency counter with 0, then go to ACCESS.
- ACCESS:
  - memWriteEnable = write flag AND counter == 0, so a store issues exactly one strobe.
  - The counter increments each cycle.
  - When the counter reaches MEM_LATENCY−1, capture memReadData into the granted requester's data register and go to ACK.
  - Writes also wait the full latency.
- ACK: assert the granted requester's acknowledge, update lastGrant to that requester, and return to IDLE.
- fetchData and dataReadData each hold their last captured value until that requester's next capture. Stores do not alter dataReadData.
- Request inputs are only sampled in IDLE. A request dropped mid-transaction does not abort it; the acknowledge still pulses.
- Requesters deassert request on the edge after acknowledge. A request still high in the following IDLE cycle is treated as a new request.
- Counter width is $clog2(MEM_LATENCY) (minimum 1); no wrap is possible.

## Timing
- Reset values (any state, takes effect at the next edge):
  - State = IDLE, lastGrant = DATA (so fetch wins the first tie).
  - Counter = 0, write flag = 0.
  - All acknowledges = 0, memWriteEnable = 0.
  - memAddress, memWriteData, fetchData and dataReadData = 0.
- Reset mid-transaction aborts it with no acknowledge. A write strobe already issued is not undone.
- Latency: request high in IDLE cycle T → memAddress valid T+1 → capture at end of cycle T+MEM_LATENCY → acknowledge in cycle T+MEM_LATENCY+1. With the default of 2, acknowledge comes in cycle T+3.
- Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles, with a mandatory IDLE cycle between transactions.
- memAddress and memWriteData are stable from grant+1 through ACK.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package (cpu_pkg):
  - State enum (IDLE/ACCESS/ACK).
  - Grant ID constants GRANT_FETCH/GRANT_DATA.
  - Default MEM_LATENCY constant.
- Single module; the counter and round-robin select are inline. No sub-module is warranted.

## Test plan
- Fetch only: fetchRequest=1, fetchAddress=0x00400000, memReadData=0x8C080004 → memAddress=0x00400000 from T+1, fetchAcknowledge pulse at T+3, fetchData=0x8C080004; memWriteEnable never high.
- Store: dataRequest=1, dataWrite=1, dataAddress=0x10010008, dataWriteData=0xDEADBEEF → exactly one memWriteEnable cycle at T+1 with memWriteData=0xDEADBEEF; dataAcknowledge at T+3; dataReadData unchanged.
- Ties after reset: both requests held high continuously → grants alternate fetch, data, fetch, data; the two acknowledges alternate and are never simultaneous; spacing is 4 cycles.
- Request drop: fetchRequest high for only one cycle in IDLE → the transaction completes and fetchAcknowledge still pulses at T+3.
- Reset mid-ACCESS: resetIn asserted at T+2 → no acknowledge; the next cycle shows IDLE with all outputs 0; the next tie grants fetch.
- MEM_LATENCY=4 build: load at T → acknowledge at T+5 with the word present on memReadData in cycle T+4.
